// File: rtl/batch_eval_scheduler.sv
// Dispatches frac_wl configs to parallel FIR lanes and returns lane MSE results in acceptance order.
// Optional WAIT watchdog enabled by defining BATCH_SCHED_TIMEOUT_EN.
module batch_eval_scheduler #(
  parameter int NUM_CHAN    = 15,
  parameter int NUM_LANES   = 2,
  parameter int MSE_W       = 64,
  parameter int SETTLE_CYC  = 32,
  parameter int TIMEOUT_CYC = 1 << 20
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              cfg_valid,
  output logic                              cfg_ready,
  input  logic [NUM_CHAN*8-1:0]             cfg_frac,
  input  logic                              cfg_last,
  input  logic                              abort,
  output logic [NUM_LANES*NUM_CHAN*8-1:0]   lane_frac,
  output logic [NUM_LANES-1:0]              lane_rstn,
  output logic [NUM_LANES-1:0]              lane_start,
  input  logic [NUM_LANES*MSE_W-1:0]        lane_mse,
  input  logic [NUM_LANES-1:0]              lane_mse_valid,
  output logic                              res_valid,
  input  logic                              res_ready,
  output logic [MSE_W-1:0]                  res_data,
  output logic [7:0]                        res_idx,
  output logic                              res_last,
  output logic                              res_timeout,
  output logic                              busy
);
  localparam int FW      = NUM_CHAN * 8;
  localparam int CNT_MAX = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int LANE_W  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  typedef enum logic [2:0] {L_IDLE, L_SETTLE, L_START, L_WAIT, L_DONE} lane_st_e;

  logic [NUM_LANES-1:0]       idle_vec, done_vec, disp_vec, last_vec;
  logic [NUM_LANES*8-1:0]     idx_vec;
  logic [NUM_LANES*2-1:0]     tag_vec;
  logic [NUM_LANES*MSE_W-1:0] mse_vec;
`ifdef BATCH_SCHED_TIMEOUT_EN
  logic [NUM_LANES-1:0]       tout_vec;
  logic                       res_tout_q;
`endif

  logic [7:0]        in_idx_q, out_idx_q, res_idx_q;
  logic [1:0]        in_tag_q, out_tag_q;
  logic              res_valid_q, res_last_q;
  logic [MSE_W-1:0]  res_data_q;
  logic [LANE_W-1:0] res_lane_q, load_sel;
  logic              cfg_fire, res_fire, load_any, disp_found;

  // Batch tags keep index-0 results of consecutive batches apart while several are in flight.
  always_comb begin
    disp_vec   = '0;
    disp_found = 1'b0;
    load_any   = 1'b0;
    load_sel   = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (idle_vec[l] && !disp_found) begin
        disp_vec[l] = 1'b1;
        disp_found  = 1'b1;
      end
      if (done_vec[l] && !load_any && idx_vec[l*8 +: 8] == out_idx_q &&
          tag_vec[l*2 +: 2] == out_tag_q) begin
        load_any = 1'b1;
        load_sel = LANE_W'(l);
      end
    end
  end

  assign cfg_ready = rstn & ~abort & (|idle_vec);
  assign cfg_fire  = cfg_valid & cfg_ready;
  assign res_fire  = res_valid_q & res_ready;
  assign busy      = ~(&idle_vec) | res_valid_q;

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    lane_st_e         st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [FW-1:0]    frac_q;
    logic [7:0]       idx_q;
    logic [1:0]       tag_q;
    logic             last_q;
    logic [MSE_W-1:0] mse_q, mse_d;
`ifdef BATCH_SCHED_TIMEOUT_EN
    logic             tout_q, tout_d;
`endif

    always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      mse_d = mse_q;
`ifdef BATCH_SCHED_TIMEOUT_EN
      tout_d = tout_q;
`endif
      case (st_q)
        L_IDLE: if (cfg_fire && disp_vec[gi]) begin
          st_d  = L_SETTLE;
          cnt_d = '0;
        end
        L_SETTLE: if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
          st_d  = L_START;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        L_START: st_d = L_WAIT;
        L_WAIT: if (lane_mse_valid[gi]) begin
          st_d  = L_DONE;
          mse_d = lane_mse[gi*MSE_W +: MSE_W];
`ifdef BATCH_SCHED_TIMEOUT_EN
          tout_d = 1'b0;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          st_d   = L_DONE;
          mse_d  = '1;
          tout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end
        L_DONE: if (res_fire && res_lane_q == LANE_W'(gi)) st_d = L_IDLE;
        default: st_d = L_IDLE;
      endcase
      if (abort) st_d = L_IDLE;
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        st_q   <= L_IDLE;
        cnt_q  <= '0;
        frac_q <= '0;
        idx_q  <= '0;
        tag_q  <= '0;
        last_q <= 1'b0;
        mse_q  <= '0;
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
        mse_q <= mse_d;
        if (cfg_fire && disp_vec[gi]) begin
          frac_q <= cfg_frac;
          idx_q  <= in_idx_q;
          tag_q  <= in_tag_q;
          last_q <= cfg_last;
        end
      end
    end

`ifdef BATCH_SCHED_TIMEOUT_EN
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) tout_q <= 1'b0;
      else       tout_q <= tout_d;
    end
    assign tout_vec[gi] = tout_q;
`endif

    assign idle_vec[gi]            = (st_q == L_IDLE);
    assign done_vec[gi]            = (st_q == L_DONE);
    assign idx_vec[gi*8 +: 8]      = idx_q;
    assign tag_vec[gi*2 +: 2]      = tag_q;
    assign last_vec[gi]            = last_q;
    assign mse_vec[gi*MSE_W +: MSE_W] = mse_q;
    assign lane_frac[gi*FW +: FW]  = frac_q;
    assign lane_rstn[gi]           = (st_q != L_IDLE);
    assign lane_start[gi]          = (st_q == L_START);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_idx_q    <= '0;
      out_idx_q   <= '0;
      in_tag_q    <= '0;
      out_tag_q   <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_idx_q   <= '0;
      res_last_q  <= 1'b0;
      res_lane_q  <= '0;
`ifdef BATCH_SCHED_TIMEOUT_EN
      res_tout_q  <= 1'b0;
`endif
    end else if (abort) begin
      in_idx_q    <= '0;
      out_idx_q   <= '0;
      in_tag_q    <= '0;
      out_tag_q   <= '0;
      res_valid_q <= 1'b0;
    end else begin
      if (cfg_fire) begin
        if (cfg_last) begin
          in_idx_q <= '0;
          in_tag_q <= in_tag_q + 2'd1;
        end else begin
          in_idx_q <= in_idx_q + 8'd1;
        end
      end
      if (res_fire) begin
        res_valid_q <= 1'b0;
        if (res_last_q) begin
          out_idx_q <= '0;
          out_tag_q <= out_tag_q + 2'd1;
        end else begin
          out_idx_q <= out_idx_q + 8'd1;
        end
      end else if (!res_valid_q && load_any) begin
        res_valid_q <= 1'b1;
        res_data_q  <= mse_vec[int'(load_sel)*MSE_W +: MSE_W];
        res_idx_q   <= idx_vec[int'(load_sel)*8 +: 8];
        res_last_q  <= last_vec[load_sel];
        res_lane_q  <= load_sel;
`ifdef BATCH_SCHED_TIMEOUT_EN
        res_tout_q  <= tout_vec[load_sel];
`endif
      end
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_idx   = res_idx_q;
  assign res_last  = res_last_q;
`ifdef BATCH_SCHED_TIMEOUT_EN
  assign res_timeout = res_tout_q;
`else
  assign res_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_batch_eval_scheduler.sv
// Self-checking bench for batch_eval_scheduler: directed scenarios plus random traffic against a
// cycle-arithmetic reference model (lane occupancy, expected-result queue in acceptance order).
module tb_batch_eval_scheduler;
  localparam int NC = 15;
  localparam int NL = 2;
  localparam int MW = 64;
  localparam int SC = 4;
  localparam int TO = 64;
  localparam int FW = NC * 8;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [FW-1:0]     cfg_frac = '0;
  logic              cfg_last = 1'b0;
  logic              abort = 1'b0;
  logic [NL*FW-1:0]  lane_frac;
  logic [NL-1:0]     lane_rstn;
  logic [NL-1:0]     lane_start;
  logic [NL*MW-1:0]  lane_mse = '0;
  logic [NL-1:0]     lane_mse_valid = '0;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic [MW-1:0]     res_data;
  logic [7:0]        res_idx;
  logic              res_last;
  logic              res_timeout;
  logic              busy;

  batch_eval_scheduler #(
    .NUM_CHAN(NC), .NUM_LANES(NL), .MSE_W(MW), .SETTLE_CYC(SC), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rstn(rstn), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_frac(cfg_frac), .cfg_last(cfg_last), .abort(abort), .lane_frac(lane_frac),
    .lane_rstn(lane_rstn), .lane_start(lane_start), .lane_mse(lane_mse),
    .lane_mse_valid(lane_mse_valid), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_idx(res_idx), .res_last(res_last),
    .res_timeout(res_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          lane;
    logic [7:0]  idx;
    logic        last;
    logic [MW-1:0] mse;
    logic        tout;
    int          d;      // first cycle the lane holds its result
  } res_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_hs = -100;
  res_t q[$];
  bit   occ[NL];
  int   start_c[NL];
  int   pulse_c[NL];
  bit   nop_m[NL];
  logic [FW-1:0] frac_m[NL];
  logic [MW-1:0] mse_m[NL];
  logic [7:0] in_idx_m = '0;
  logic [MW-1:0] nxt_mse = '0;
  int   nxt_delay = 0;
  bit   nxt_nop = 1'b0;
  bit   spur_en = 1'b0;
  bit   acc = 1'b0;

  function automatic logic [FW-1:0] rand_frac();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[FW-1:0];
  endfunction

  function automatic logic [MW-1:0] rand64();
    return {$urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h cyc=%0d", tag, obs, expv, cyc);
    end
  endtask

  // One clock cycle: drive collector responses, check outputs, advance the model across the edge.
  task automatic step();
    logic [NL*MW-1:0] mse_drv;
    logic [NL-1:0]    mv_drv;
    bit exp_rdy, exp_rv, any_occ;
    int avail, dl;
    mse_drv = '0;
    mv_drv  = '0;
    for (int l = 0; l < NL; l++) begin
      if (occ[l] && !nop_m[l] && cyc == pulse_c[l]) begin
        mv_drv[l] = 1'b1;
        mse_drv[l*MW +: MW] = mse_m[l];
      end else if (spur_en && (!occ[l] || cyc <= start_c[l] || cyc > pulse_c[l]) &&
                   $urandom_range(0, 3) == 0) begin
        mv_drv[l] = 1'b1;
        mse_drv[l*MW +: MW] = rand64();
      end
    end
    lane_mse_valid = mv_drv;
    lane_mse = mse_drv;
    #1;
    any_occ = 1'b0;
    exp_rdy = 1'b0;
    for (int l = 0; l < NL; l++) begin
      if (occ[l]) any_occ = 1'b1;
      else if (!abort) exp_rdy = 1'b1;
    end
    exp_rv = 1'b0;
    if (q.size() > 0) begin
      avail = q[0].d + 1;
      if (last_hs + 2 > avail) avail = last_hs + 2;
      exp_rv = (cyc >= avail);
    end
    chk("cfg_ready", cfg_ready, exp_rdy);
    chk("res_valid", res_valid, exp_rv);
    chk("busy", busy, any_occ);
    for (int l = 0; l < NL; l++) begin
      chk($sformatf("lane_rstn%0d", l), lane_rstn[l], occ[l]);
      chk($sformatf("lane_start%0d", l), lane_start[l], occ[l] && cyc == start_c[l]);
      if (occ[l]) chk($sformatf("lane_frac%0d", l), lane_frac[l*FW +: FW], frac_m[l]);
    end
    if (exp_rv) begin
      chk("res_data", res_data, q[0].mse);
      chk("res_idx", res_idx, q[0].idx);
      chk("res_last", res_last, q[0].last);
      chk("res_timeout", res_timeout, q[0].tout);
    end
    if (abort) begin
      for (int l = 0; l < NL; l++) occ[l] = 1'b0;
      q.delete();
      in_idx_m = '0;
      last_hs = -100;
      $display("abort cyc=%0d", cyc);
    end else begin
      dl = -1;
      if (cfg_valid && exp_rdy) begin
        for (int l = NL - 1; l >= 0; l--) if (!occ[l]) dl = l;
      end
      if (exp_rv && res_ready) begin
        $display("res idx=%0d last=%0b data=%h tout=%0b lane=%0d cyc=%0d",
                 q[0].idx, q[0].last, q[0].mse, q[0].tout, q[0].lane, cyc);
        occ[q[0].lane] = 1'b0;
        last_hs = cyc;
        void'(q.pop_front());
      end
      if (dl >= 0) begin
        res_t e;
        occ[dl]     = 1'b1;
        nop_m[dl]   = nxt_nop;
        start_c[dl] = cyc + 1 + SC;
        pulse_c[dl] = nxt_nop ? start_c[dl] + TO : start_c[dl] + 1 + nxt_delay;
        frac_m[dl]  = cfg_frac;
        mse_m[dl]   = nxt_nop ? {MW{1'b1}} : nxt_mse;
        e.lane = dl; e.idx = in_idx_m; e.last = cfg_last; e.mse = mse_m[dl];
        e.tout = nxt_nop; e.d = pulse_c[dl] + 1;
        q.push_back(e);
        $display("cfg idx=%0d last=%0b lane=%0d cyc=%0d", in_idx_m, cfg_last, dl, cyc);
        in_idx_m = cfg_last ? 8'd0 : in_idx_m + 8'd1;
        acc = 1'b1;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic offer(input logic last, input logic [MW-1:0] mse, input int dly, input bit nop);
    cfg_valid = 1'b1;
    cfg_last  = last;
    cfg_frac  = rand_frac();
    nxt_mse   = mse;
    nxt_delay = dly;
    nxt_nop   = nop;
    acc = 1'b0;
    for (int i = 0; i < 200 && !acc; i++) step();
    total++;
    assert (acc) else begin
      bad++;
      $error("FAIL offer_accept observed=0 expected=1 cyc=%0d", cyc);
    end
    cfg_valid = 1'b0;
    nxt_nop = 1'b0;
  endtask

  task automatic drain(input int maxc);
    res_ready = 1'b1;
    for (int i = 0; i < maxc && q.size() > 0; i++) step();
    chk("drain_pending", q.size(), 0);
    step();
  endtask

  initial begin
    for (int l = 0; l < NL; l++) begin
      occ[l] = 1'b0; start_c[l] = -1; pulse_c[l] = -1; nop_m[l] = 1'b0;
      frac_m[l] = '0; mse_m[l] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cfg_ready", cfg_ready, 1'b0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_lane_rstn", lane_rstn, '0);
    chk("rst_lane_start", lane_start, '0);
    chk("rst_lane_frac", lane_frac, '0);
    chk("rst_res_data", res_data, '0);
    chk("rst_busy", busy, 1'b0);
    rstn = 1'b1;

    // single config with known MSE
    offer(1'b1, 64'h1234, 2, 1'b0);
    drain(60);

    // three back-to-back configs, third waits for a freed lane
    res_ready = 1'b1;
    offer(1'b0, rand64(), 3, 1'b0);
    offer(1'b0, rand64(), 3, 1'b0);
    offer(1'b1, rand64(), 3, 1'b0);
    drain(80);

    // lane1 finishes well before lane0
    offer(1'b0, rand64(), 14, 1'b0);
    offer(1'b1, rand64(), 0, 1'b0);
    drain(80);

    // consumer stalls for 20 cycles
    res_ready = 1'b0;
    offer(1'b0, rand64(), 1, 1'b0);
    offer(1'b1, rand64(), 1, 1'b0);
    repeat (20) step();
    drain(80);

    // abort while a result is pending and another lane waits
    res_ready = 1'b0;
    offer(1'b0, rand64(), 3, 1'b0);
    offer(1'b1, rand64(), 40, 1'b0);
    repeat (12) step();
    chk("abort_pre_res_valid", res_valid, 1'b1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    step();
    res_ready = 1'b1;
    offer(1'b1, rand64(), 2, 1'b0);
    drain(60);

    // random traffic with spurious mse_valid and occasional abort
    spur_en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      cfg_valid = 1'($urandom_range(0, 1));
      cfg_last  = ($urandom_range(0, 3) == 0);
      cfg_frac  = rand_frac();
      nxt_mse   = rand64();
      nxt_delay = $urandom_range(0, 15);
      res_ready = 1'($urandom_range(0, 1));
      abort     = ($urandom_range(0, 99) == 0);
      step();
    end
    abort = 1'b0;
    cfg_valid = 1'b0;
    drain(200);
    spur_en = 1'b0;

`ifdef BATCH_SCHED_TIMEOUT_EN
    offer(1'b1, '0, 0, 1'b1);
    drain(200);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
